// File: rtl/video_timing_gen.sv
// Video timing generator: free-running pixel/line counters driving registered
// DE, HSYNC, VSYNC, active-area coordinates and line/frame start pulses.
// Timing inputs are sampled once per frame so each frame is self-consistent.
module video_timing_gen #(
  parameter int unsigned CNT_W   = 12,
  parameter int unsigned OUT_REG = 1
) (
  input  logic             I_pxl_clk,
  input  logic             I_rst_n,
  input  logic             I_en,
  input  logic [CNT_W-1:0] I_h_total,
  input  logic [CNT_W-1:0] I_h_sync,
  input  logic [CNT_W-1:0] I_h_bporch,
  input  logic [CNT_W-1:0] I_h_res,
  input  logic [CNT_W-1:0] I_v_total,
  input  logic [CNT_W-1:0] I_v_sync,
  input  logic [CNT_W-1:0] I_v_bporch,
  input  logic [CNT_W-1:0] I_v_res,
  input  logic             I_hs_pol,
  input  logic             I_vs_pol,
  output logic             O_de,
  output logic             O_hs,
  output logic             O_vs,
  output logic [CNT_W-1:0] O_x,
  output logic [CNT_W-1:0] O_y,
  output logic             O_frame_start,
  output logic             O_line_start
);

  // Only the registered-output variant exists.
  if (OUT_REG != 1) begin : gen_out_reg_check
    $error("video_timing_gen: OUT_REG must be 1");
  end

  localparam logic [CNT_W-1:0] HTotalRst  = CNT_W'(1650);
  localparam logic [CNT_W-1:0] HSyncRst   = CNT_W'(40);
  localparam logic [CNT_W-1:0] HBporchRst = CNT_W'(220);
  localparam logic [CNT_W-1:0] HResRst    = CNT_W'(1280);
  localparam logic [CNT_W-1:0] VTotalRst  = CNT_W'(750);
  localparam logic [CNT_W-1:0] VSyncRst   = CNT_W'(5);
  localparam logic [CNT_W-1:0] VBporchRst = CNT_W'(20);
  localparam logic [CNT_W-1:0] VResRst    = CNT_W'(720);
  localparam logic [CNT_W-1:0] MinTotal   = CNT_W'(2);
  localparam logic [CNT_W-1:0] One        = CNT_W'(1);

  logic             started_q;
  logic [CNT_W-1:0] h_cnt_q, v_cnt_q, h_cnt_d, v_cnt_d;

  logic [CNT_W-1:0] h_total_l, h_sync_l, h_bporch_l, h_res_l;
  logic [CNT_W-1:0] v_total_l, v_sync_l, v_bporch_l, v_res_l;
  logic             hs_pol_l, vs_pol_l;

  // Timing set in effect for the current counter state. Before the first
  // enabled edge the shadows hold reset defaults, so the live inputs are used.
  logic [CNT_W-1:0] h_total_e, h_sync_e, h_bporch_e, h_res_e;
  logic [CNT_W-1:0] v_total_e, v_sync_e, v_bporch_e, v_res_e;
  logic             hs_pol_e, vs_pol_e;

  logic [CNT_W-1:0] h_tot_c, v_tot_c;
  logic             h_last, v_last, load;
  logic [CNT_W:0]   h_start, h_end, v_start, v_end;
  logic [CNT_W-1:0] h_start_n, v_start_n;
  logic             h_act, v_act, de_c, hs_c, vs_c;
  logic [CNT_W-1:0] x_c, y_c;

  // Select effective timing, derive wrap conditions and next counter state.
  always_comb begin
    h_total_e  = started_q ? h_total_l  : I_h_total;
    h_sync_e   = started_q ? h_sync_l   : I_h_sync;
    h_bporch_e = started_q ? h_bporch_l : I_h_bporch;
    h_res_e    = started_q ? h_res_l    : I_h_res;
    v_total_e  = started_q ? v_total_l  : I_v_total;
    v_sync_e   = started_q ? v_sync_l   : I_v_sync;
    v_bporch_e = started_q ? v_bporch_l : I_v_bporch;
    v_res_e    = started_q ? v_res_l    : I_v_res;
    hs_pol_e   = started_q ? hs_pol_l   : I_hs_pol;
    vs_pol_e   = started_q ? vs_pol_l   : I_vs_pol;

    // Degenerate totals are clamped so "total - 1" never underflows.
    h_tot_c = (h_total_e < MinTotal) ? MinTotal : h_total_e;
    v_tot_c = (v_total_e < MinTotal) ? MinTotal : v_total_e;
    h_last  = (h_cnt_q >= h_tot_c - One);
    v_last  = (v_cnt_q >= v_tot_c - One);

    h_cnt_d = h_cnt_q + One;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = v_last ? '0 : v_cnt_q + One;
    end

    load = I_en & ((h_last & v_last) | ~started_q);
  end

  // Decode active windows, syncs and coordinates from the current state.
  always_comb begin
    h_start   = {1'b0, h_sync_e} + {1'b0, h_bporch_e};
    h_end     = h_start + {1'b0, h_res_e};
    v_start   = {1'b0, v_sync_e} + {1'b0, v_bporch_e};
    v_end     = v_start + {1'b0, v_res_e};
    h_start_n = h_sync_e + h_bporch_e;
    v_start_n = v_sync_e + v_bporch_e;

    h_act = ({1'b0, h_cnt_q} >= h_start) && ({1'b0, h_cnt_q} < h_end);
    v_act = ({1'b0, v_cnt_q} >= v_start) && ({1'b0, v_cnt_q} < v_end);
    de_c  = h_act & v_act;
    hs_c  = (h_cnt_q < h_sync_e) ~^ hs_pol_e;
    vs_c  = (v_cnt_q < v_sync_e) ~^ vs_pol_e;
    x_c   = de_c ? (h_cnt_q - h_start_n) : '0;
    y_c   = de_c ? (v_cnt_q - v_start_n) : '0;
  end

  // Pixel/line counters and the started flag.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      started_q <= 1'b0;
    end else if (I_en) begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      started_q <= 1'b1;
    end
  end

  // Per-frame shadow copy of the timing inputs.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      h_total_l  <= HTotalRst;
      h_sync_l   <= HSyncRst;
      h_bporch_l <= HBporchRst;
      h_res_l    <= HResRst;
      v_total_l  <= VTotalRst;
      v_sync_l   <= VSyncRst;
      v_bporch_l <= VBporchRst;
      v_res_l    <= VResRst;
      hs_pol_l   <= 1'b1;
      vs_pol_l   <= 1'b1;
    end else if (load) begin
      h_total_l  <= I_h_total;
      h_sync_l   <= I_h_sync;
      h_bporch_l <= I_h_bporch;
      h_res_l    <= I_h_res;
      v_total_l  <= I_v_total;
      v_sync_l   <= I_v_sync;
      v_bporch_l <= I_v_bporch;
      v_res_l    <= I_v_res;
      hs_pol_l   <= I_hs_pol;
      vs_pol_l   <= I_vs_pol;
    end
  end

  // Output registers, one cycle behind the counter state they decode.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_de          <= 1'b0;
      O_hs          <= 1'b0;
      O_vs          <= 1'b0;
      O_x           <= '0;
      O_y           <= '0;
      O_frame_start <= 1'b0;
      O_line_start  <= 1'b0;
    end else if (I_en) begin
      O_de          <= de_c;
      O_hs          <= hs_c;
      O_vs          <= vs_c;
      O_x           <= x_c;
      O_y           <= y_c;
      O_frame_start <= (h_cnt_q == '0) && (v_cnt_q == '0);
      O_line_start  <= (h_cnt_q == '0);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: a frame-position model compared
// every cycle, plus directed literal checks of periods, widths and pulses.
module tb_video_timing_gen;

  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic [CW-1:0] h_total, h_sync, h_bporch, h_res;
  logic [CW-1:0] v_total, v_sync, v_bporch, v_res;
  logic          hs_pol, vs_pol;
  logic          o_de, o_hs, o_vs, o_fs, o_ls;
  logic [CW-1:0] o_x, o_y;

  int n_assert = 0;
  int n_fail = 0;
  int n_print = 0;
  int cyc = 0;
  int last_fs_cyc = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .CNT_W  (CW),
    .OUT_REG(1)
  ) dut (
    .I_pxl_clk    (clk),
    .I_rst_n      (rst_n),
    .I_en         (en),
    .I_h_total    (h_total),
    .I_h_sync     (h_sync),
    .I_h_bporch   (h_bporch),
    .I_h_res      (h_res),
    .I_v_total    (v_total),
    .I_v_sync     (v_sync),
    .I_v_bporch   (v_bporch),
    .I_v_res      (v_res),
    .I_hs_pol     (hs_pol),
    .I_vs_pol     (vs_pol),
    .O_de         (o_de),
    .O_hs         (o_hs),
    .O_vs         (o_vs),
    .O_x          (o_x),
    .O_y          (o_y),
    .O_frame_start(o_fs),
    .O_line_start (o_ls)
  );

  typedef struct packed {
    int htot; int hsync; int hbp; int hres;
    int vtot; int vsync; int vbp; int vres;
    logic hpol; logic vpol;
  } timing_t;

  typedef struct packed {
    logic de; logic hs; logic vs; logic fs; logic ls;
    int x; int y;
  } outs_t;

  function automatic timing_t cur_inputs();
    timing_t t;
    t.htot = int'(h_total);  t.hsync = int'(h_sync);
    t.hbp  = int'(h_bporch); t.hres  = int'(h_res);
    t.vtot = int'(v_total);  t.vsync = int'(v_sync);
    t.vbp  = int'(v_bporch); t.vres  = int'(v_res);
    t.hpol = hs_pol;         t.vpol  = vs_pol;
    return t;
  endfunction

  function automatic int clamp2(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  // Outputs for linear position k within a frame of timing t.
  function automatic outs_t eval(input timing_t t, input int k);
    outs_t o;
    int ht, h, v, hst, vst;
    logic ha, va;
    ht  = clamp2(t.htot);
    h   = k % ht;
    v   = k / ht;
    hst = t.hsync + t.hbp;
    vst = t.vsync + t.vbp;
    ha  = (h >= hst) && (h < hst + t.hres);
    va  = (v >= vst) && (v < vst + t.vres);
    o.de = ha && va;
    o.hs = ((h < t.hsync) == t.hpol);
    o.vs = ((v < t.vsync) == t.vpol);
    o.x  = o.de ? h - hst : 0;
    o.y  = o.de ? v - vst : 0;
    o.ls = (h == 0);
    o.fs = (k == 0);
    return o;
  endfunction

  timing_t m_t;
  int      m_k;
  logic    m_started;
  outs_t   m_exp;

  // Frame-position model: one linear index per frame, timing reloaded at wrap.
  always @(posedge clk or negedge rst_n) begin : model_p
    timing_t t;
    int k;
    if (!rst_n) begin
      m_k       <= 0;
      m_started <= 1'b0;
      m_t       <= '0;
      m_exp     <= '0;
    end else if (en) begin
      t = m_started ? m_t : cur_inputs();
      m_exp <= eval(t, m_k);
      k = m_k + 1;
      if (k >= clamp2(t.htot) * clamp2(t.vtot)) begin
        k = 0;
        m_t <= cur_inputs();
      end else begin
        m_t <= t;
      end
      m_k       <= k;
      m_started <= 1'b1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Every-cycle comparison against the model.
  always @(negedge clk) begin : cmp_p
    outs_t got;
    if (chk_on) begin
      got.de = o_de; got.hs = o_hs; got.vs = o_vs; got.fs = o_fs; got.ls = o_ls;
      got.x = int'(o_x); got.y = int'(o_y);
      n_assert++;
      if (got != m_exp) begin
        n_fail++;
        if (n_print < 20) begin
          n_print++;
          $display("FAIL model_cmp t=%0t got de%0b hs%0b vs%0b fs%0b ls%0b x%0d y%0d, expected de%0b hs%0b vs%0b fs%0b ls%0b x%0d y%0d",
                   $time, got.de, got.hs, got.vs, got.fs, got.ls, got.x, got.y,
                   m_exp.de, m_exp.hs, m_exp.vs, m_exp.fs, m_exp.ls, m_exp.x, m_exp.y);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_assert++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic set_timing(input int ht, input int hs, input int hb, input int hr,
                            input int vt, input int vs, input int vb, input int vr);
    h_total = CW'(ht); h_sync = CW'(hs); h_bporch = CW'(hb); h_res = CW'(hr);
    v_total = CW'(vt); v_sync = CW'(vs); v_bporch = CW'(vb); v_res = CW'(vr);
  endtask

  // Wait for the next frame-start pulse and check the cycles since the last one.
  task automatic wait_fs(input string name, input int exp_period);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_fs && n < 5000);
    chk(name, o_fs ? (cyc - last_fs_cyc) : -1, exp_period);
    last_fs_cyc = cyc;
  endtask

  // From a frame-start cycle, walk to the next one gathering frame statistics.
  task automatic count_frame(output int per, output int de_n, output int vs_n,
                             output int mx, output int my);
    int n;
    de_n = 0; vs_n = 0; mx = 0; my = 0; n = 0;
    do begin
      if (o_de) begin
        de_n++;
        if (int'(o_x) > mx) mx = int'(o_x);
        if (int'(o_y) > my) my = int'(o_y);
      end
      if (o_vs) vs_n++;
      @(negedge clk);
      n++;
    end while (!o_fs && n < 5000);
    per = o_fs ? n : -1;
    last_fs_cyc = cyc;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_de"}, int'(o_de), 0);
    chk({tag, "_hs"}, int'(o_hs), 0);
    chk({tag, "_vs"}, int'(o_vs), 0);
    chk({tag, "_x"},  int'(o_x), 0);
    chk({tag, "_y"},  int'(o_y), 0);
    chk({tag, "_fs"}, int'(o_fs), 0);
    chk({tag, "_ls"}, int'(o_ls), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int hs0, ls2, vs_n, first_de, de_n, x_first, x_last, y_first;
    int per, fde, fvs, mx, my, n, x_hold;

    set_timing(1650, 40, 220, 1280, 750, 5, 20, 720);
    hs_pol = 1'b1;
    vs_pol = 1'b1;
    #3 rst_n = 1'b0;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");

    // 720p start-up.
    rst_n = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    chk("first_fs_720p", int'(o_fs), 1);
    last_fs_cyc = cyc;

    hs0 = 0; ls2 = -1; vs_n = 0; first_de = -1; de_n = 0;
    x_first = -1; x_last = -1; y_first = -1;
    for (int i = 0; i < 26 * 1650; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 1650 && o_hs) hs0++;
      if (i > 0 && o_ls && ls2 < 0) ls2 = i;
      if (o_vs) vs_n++;
      if (o_de) begin
        if (first_de < 0) begin
          first_de = i; x_first = int'(o_x); y_first = int'(o_y);
        end
        de_n++;
        x_last = int'(o_x);
      end
    end
    chk("720p_hs_width", hs0, 40);
    chk("720p_line_period", ls2, 1650);
    chk("720p_vs_width", vs_n, 5 * 1650);
    chk("720p_first_de", first_de, 25 * 1650 + 260);
    chk("720p_de_width", de_n, 1280);
    chk("720p_x_first", x_first, 0);
    chk("720p_x_last", x_last, 1279);
    chk("720p_y_first", y_first, 0);

    // Asynchronous reset in the middle of an active line.
    repeat (300) @(negedge clk);
    chk("pre_reset_de", int'(o_de), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("midframe_reset");

    // Small timing A: 20x12 frame, active 10x5.
    @(negedge clk);
    set_timing(20, 3, 4, 10, 12, 2, 3, 5);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_fs_after_reset", int'(o_fs), 1);
    last_fs_cyc = cyc;
    count_frame(per, fde, fvs, mx, my);
    chk("A_period", per, 240);
    chk("A_de_cycles", fde, 50);
    chk("A_vs_cycles", fvs, 40);
    chk("A_max_x", mx, 9);
    chk("A_max_y", my, 4);

    // Negative polarity requested mid-frame.
    repeat (30) @(negedge clk);
    hs_pol = 1'b0;
    vs_pol = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_ls && n < 100);
    chk("pol_old_hs_at_line_start", int'(o_hs), 1);
    wait_fs("A_period_pol", 240);
    chk("pol_new_hs_at_fs", int'(o_hs), 0);
    chk("pol_new_vs_at_fs", int'(o_vs), 0);

    // Timing B requested mid-line: current frame completes unchanged.
    repeat (25) @(negedge clk);
    set_timing(16, 2, 2, 8, 10, 1, 2, 4);
    wait_fs("A_period_before_switch", 240);
    wait_fs("B_period", 160);

    // Enable stall inside the active area.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_de && n < 200);
    repeat (2) @(negedge clk);
    x_hold = int'(o_x);
    en = 1'b0;
    repeat (100) @(negedge clk);
    chk("stall_x_hold", int'(o_x), x_hold);
    chk("stall_de_hold", int'(o_de), 1);
    en = 1'b1;
    @(negedge clk);
    chk("stall_x_next", int'(o_x), x_hold + 1);
    wait_fs("B_period_stall", 260);

    // Degenerate totals clamp to 2; oversized windows truncate at the wrap.
    set_timing(0, 1, 0, 10, 1, 1, 0, 3);
    wait_fs("B_period_before_tiny", 160);
    wait_fs("tiny_period", 4);
    wait_fs("tiny_period_again", 4);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
